// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared constants and types for the VGA pixel path: default
//               resolution, coordinate/colour widths, 3-bit RGB colour
//               names and the frame sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Default resolution of the VGA adapter (160x120, 3-bit colour)
  localparam int X_PIXELS_DEF = 160;
  localparam int Y_PIXELS_DEF = 120;

  // Coordinate and colour widths as seen on the adapter ports
  localparam int X_W     = 8;
  localparam int Y_W     = 7;
  localparam int COLOR_W = 3;

  // 3-bit RGB colours {R,G,B}
  localparam logic [COLOR_W-1:0] BLACK   = 3'b000;
  localparam logic [COLOR_W-1:0] BLUE    = 3'b001;
  localparam logic [COLOR_W-1:0] GREEN   = 3'b010;
  localparam logic [COLOR_W-1:0] CYAN    = 3'b011;
  localparam logic [COLOR_W-1:0] RED     = 3'b100;
  localparam logic [COLOR_W-1:0] MAGENTA = 3'b101;
  localparam logic [COLOR_W-1:0] YELLOW  = 3'b110;
  localparam logic [COLOR_W-1:0] WHITE   = 3'b111;

  // Frame sequencer states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CLEAR      = 3'd1,
    ST_START_DRAW = 3'd2,
    ST_DRAW       = 3'd3,
    ST_DONE       = 3'd4
  } seq_state_t;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_xy_sweep_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_xy_sweep_counter
// Description : Raster-order x/y counter. x advances every enabled cycle and
//               wraps into a y increment; after the final pixel both wrap to
//               zero so the outputs never leave the visible range.
// Ports       : clock, resetn     - clock, async active-low reset
//               enable            - advance one pixel this cycle
//               clear             - force (0,0); has priority over enable
//               x, y              - current pixel coordinate
//               last_pixel        - current pixel is (X_PIXELS-1, Y_PIXELS-1)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_xy_sweep_counter
  import vga_pkg::*;
#(
  parameter int X_PIXELS = X_PIXELS_DEF,
  parameter int Y_PIXELS = Y_PIXELS_DEF
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           enable,
  input  logic           clear,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last_pixel
);

  localparam logic [X_W-1:0] X_LAST = X_W'(X_PIXELS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_PIXELS - 1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (enable) begin
      if (x == X_LAST) begin
        x <= '0;
        // Wrapping y after the last row leaves the counter at (0,0), ready
        // for the next frame without an explicit clear.
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign last_pixel = (x == X_LAST) && (y == Y_LAST);

endmodule : vga_xy_sweep_counter
`default_nettype wire

// File: rtl/vga_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_sequencer
// Description : Per-frame controller for the VGA pixel path. On a frame tick
//               it sweeps CLEAR_COLOR over every pixel, pulses draw_go to the
//               game-object drawer, passes its plot strobe through until
//               draw_done, then signals frame_done and returns to idle.
//               Ticks arriving while busy queue one pending frame and set a
//               sticky overrun flag.
// Ports       : clock, resetn          - clock, async active-low reset
//               frame_tick             - new-frame request pulse
//               draw_plot, draw_done   - plot strobe / finish pulse from drawer
//               send_clear_or_regular  - VGA mux select (0 clear, 1 regular)
//               x_clear, y_clear       - clear sweep coordinate
//               color_clear            - clear sweep colour (CLEAR_COLOR)
//               plot                   - VGA write enable
//               draw_go                - start pulse to the drawer
//               busy                   - sequencer not idle
//               frame_done             - frame complete pulse
//               overrun                - sticky: tick seen while busy
// Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_sequencer
  import vga_pkg::*;
#(
  parameter int                   X_PIXELS    = X_PIXELS_DEF,
  parameter int                   Y_PIXELS    = Y_PIXELS_DEF,
  parameter logic [COLOR_W-1:0]   CLEAR_COLOR = BLACK
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               frame_tick,
  input  logic               draw_plot,
  input  logic               draw_done,
  output logic               send_clear_or_regular,
  output logic [X_W-1:0]     x_clear,
  output logic [Y_W-1:0]     y_clear,
  output logic [COLOR_W-1:0] color_clear,
  output logic               plot,
  output logic               draw_go,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun
);

  seq_state_t state;
  logic       pending;
  logic       plot_q;
  logic       start_frame;
  logic       last_pixel;

  assign start_frame = (state == ST_IDLE) && (frame_tick || pending);

  vga_xy_sweep_counter #(
    .X_PIXELS (X_PIXELS),
    .Y_PIXELS (Y_PIXELS)
  ) u_sweep (
    .clock      (clock),
    .resetn     (resetn),
    .enable     (state == ST_CLEAR),
    .clear      (start_frame),
    .x          (x_clear),
    .y          (y_clear),
    .last_pixel (last_pixel)
  );

  assign color_clear = CLEAR_COLOR;

  // The drawer owns the write strobe while it runs; a registered copy would
  // lag its x/y/colour by a cycle.
  assign plot = (state == ST_DRAW) ? draw_plot : plot_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state                 <= ST_IDLE;
      pending               <= 1'b0;
      plot_q                <= 1'b0;
      send_clear_or_regular <= 1'b0;
      draw_go               <= 1'b0;
      busy                  <= 1'b0;
      frame_done            <= 1'b0;
      overrun               <= 1'b0;
    end else begin
      draw_go    <= 1'b0;
      frame_done <= 1'b0;

      // Any tick outside IDLE (including the DONE cycle) queues exactly one
      // follow-up frame; repeated ticks collapse into the same request.
      if (frame_tick && (state != ST_IDLE)) begin
        pending <= 1'b1;
        overrun <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (frame_tick || pending) begin
            state                 <= ST_CLEAR;
            pending               <= 1'b0;
            plot_q                <= 1'b1;
            send_clear_or_regular <= 1'b0;
            busy                  <= 1'b1;
          end
        end

        ST_CLEAR: begin
          if (last_pixel) begin
            state                 <= ST_START_DRAW;
            plot_q                <= 1'b0;
            draw_go               <= 1'b1;
            send_clear_or_regular <= 1'b1;
          end
        end

        ST_START_DRAW: begin
          state <= ST_DRAW;
        end

        ST_DRAW: begin
          if (draw_done) begin
            state      <= ST_DONE;
            frame_done <= 1'b1;
          end
        end

        ST_DONE: begin
          state                 <= ST_IDLE;
          send_clear_or_regular <= 1'b0;
          busy                  <= 1'b0;
        end

        default: begin
          state                 <= ST_IDLE;
          plot_q                <= 1'b0;
          send_clear_or_regular <= 1'b0;
          busy                  <= 1'b0;
        end
      endcase
    end
  end

endmodule : vga_frame_sequencer
`default_nettype wire
